// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, requests instructions from the controller,
// predicts the next PC (JAL always taken, branches via a 2-bit BHT) and hands results to decode.
module ifetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    BHT_IDX_W  = 6,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  br_upd_en,
  input  logic [ADDR_WIDTH-1:0] br_upd_pc,
  input  logic                  br_taken,
  output logic                  if2ctrl_en,
  output logic [ADDR_WIDTH-1:0] next_PC,
  input  logic                  inst_rdy,
  input  logic [INST_WIDTH-1:0] inst_out,
  input  logic                  dec_full,
  output logic                  if2dec_en,
  output logic [INST_WIDTH-1:0] if2dec_inst,
  output logic [ADDR_WIDTH-1:0] if2dec_pc,
  output logic                  if2dec_is_c,
  output logic                  if2dec_pred_taken
);

  localparam logic [1:0] ST_FETCH    = 2'd0;
  localparam logic [1:0] ST_HOLD     = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam int         BHT_N       = 1 << BHT_IDX_W;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [1:0]            bht [BHT_N];

  logic                  is_c;
  logic [6:0]            opcode;
  logic signed [ADDR_WIDTH-1:0] j_off;
  logic signed [ADDR_WIDTH-1:0] b_off;
  logic [ADDR_WIDTH-1:0] npc;
  logic                  pred_taken;
  logic [BHT_IDX_W-1:0]  lk_idx;
  logic [BHT_IDX_W-1:0]  up_idx;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  assign if2ctrl_en = (state == ST_FETCH) && !flush;
  assign next_PC    = pc;
  assign lk_idx     = pc[BHT_IDX_W:1];
  assign up_idx     = br_upd_pc[BHT_IDX_W:1];
  assign is_c       = (inst_out[1:0] != 2'b11);
  assign opcode     = inst_out[6:0];
  assign j_off      = {{(ADDR_WIDTH-20){inst_out[31]}}, inst_out[19:12], inst_out[20],
                       inst_out[30:21], 1'b0};
  assign b_off      = {{(ADDR_WIDTH-12){inst_out[31]}}, inst_out[7], inst_out[30:25],
                       inst_out[11:8], 1'b0};

  // Static prediction; the BHT read sees the pre-update counter when an update hits the same entry.
  always_comb begin
    npc        = pc + (is_c ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
    pred_taken = 1'b0;
    if (!is_c && opcode == OP_JAL) begin
      npc        = $unsigned($signed(pc) + j_off);
      pred_taken = 1'b1;
    end else if (!is_c && opcode == OP_BRANCH && bht[lk_idx][1]) begin
      npc        = $unsigned($signed(pc) + b_off);
      pred_taken = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state             <= ST_FETCH;
      pc                <= RESET_PC;
      if2dec_en         <= 1'b0;
      if2dec_inst       <= '0;
      if2dec_pc         <= '0;
      if2dec_is_c       <= 1'b0;
      if2dec_pred_taken <= 1'b0;
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (rdy_in) begin
      if (br_upd_en) bht[up_idx] <= sat_update(bht[up_idx], br_taken);
      if2dec_en <= 1'b0;
      if (flush) begin
        pc    <= flush_pc;
        state <= ST_REDIRECT;
      end else begin
        case (state)
          ST_FETCH: begin
            if (inst_rdy) begin
              pc                <= npc;
              if2dec_inst       <= inst_out;
              if2dec_pc         <= pc;
              if2dec_is_c       <= is_c;
              if2dec_pred_taken <= pred_taken;
              if (dec_full) state <= ST_HOLD;
              else          if2dec_en <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (!dec_full) begin
              if2dec_en <= 1'b1;
              state     <= ST_FETCH;
            end
          end
          default: state <= ST_FETCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit: directed program-flow cases followed by randomized traffic,
// checked against a next-PC/BHT reference model.
module tb_ifetch_unit;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        is_c;
    logic        pred;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush, br_upd_en, br_taken, inst_rdy, dec_full;
  logic [31:0] flush_pc, br_upd_pc, inst_out;
  logic        if2ctrl_en, if2dec_en, if2dec_is_c, if2dec_pred_taken;
  logic [31:0] next_PC, if2dec_inst, if2dec_pc;

  int    n_cmp = 0;
  int    n_bad = 0;
  item_t sb[$];

  // reference model state
  logic [31:0] m_pc;
  int          m_bht [64];
  bit          m_hold, m_redir;
  item_t       m_held;

  ifetch_unit dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush), .flush_pc(flush_pc),
    .br_upd_en(br_upd_en), .br_upd_pc(br_upd_pc), .br_taken(br_taken),
    .if2ctrl_en(if2ctrl_en), .next_PC(next_PC), .inst_rdy(inst_rdy), .inst_out(inst_out),
    .dec_full(dec_full), .if2dec_en(if2dec_en), .if2dec_inst(if2dec_inst),
    .if2dec_pc(if2dec_pc), .if2dec_is_c(if2dec_is_c), .if2dec_pred_taken(if2dec_pred_taken)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Next PC from the instruction's meaning, with offsets built arithmetically from the fields.
  function automatic void predict(input logic [31:0] pc, input logic [31:0] inst,
                                  output logic [31:0] npc, output logic taken, output logic c);
    int off;
    c     = (inst[1:0] != 2'b11);
    taken = 1'b0;
    npc   = pc + (c ? 32'd2 : 32'd4);
    if (inst[6:0] == 7'b1101111) begin
      off   = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
              - int'(inst[31]) * (1 << 20);
      npc   = pc + 32'(off);
      taken = 1'b1;
    end else if (inst[6:0] == 7'b1100011 && m_bht[(pc >> 1) % 64] >= 2) begin
      off   = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048
              - int'(inst[31]) * 4096;
      npc   = pc + 32'(off);
      taken = 1'b1;
    end
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 4))
      0: return {r[31:7], 7'b0010011};
      1: return {r[31:2], 2'($urandom_range(0, 2))};
      2: return {r[31:7], 7'b1101111};
      3: return {r[31:7], 7'b1100011};
      default: return {r[31:7], 7'b1100111};
    endcase
  endfunction

  function automatic void model_reset();
    m_pc = 32'h0; m_hold = 1'b0; m_redir = 1'b0;
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    sb.delete();
  endfunction

  // One clock cycle; entered and left at posedge+1.
  task automatic cycle(input bit rdy, input bit fl, input logic [31:0] fpc, input bit upd,
                       input logic [31:0] upc, input bit tk, input bit irdy,
                       input logic [31:0] inst, input bit full);
    item_t it;
    logic [31:0] npc;
    rdy_in = rdy; flush = fl; flush_pc = fpc; br_upd_en = upd; br_upd_pc = upc;
    br_taken = tk; inst_rdy = irdy; inst_out = inst; dec_full = full;
    @(negedge clk); #1;
    chk("if2ctrl_en", {31'b0, if2ctrl_en}, {31'b0, !m_hold && !m_redir && !fl});
    chk("next_PC", next_PC, m_pc);
    if (rdy) begin
      if (fl) begin
        m_pc = fpc; m_redir = 1'b1; m_hold = 1'b0;
      end else if (m_redir) begin
        m_redir = 1'b0;
      end else if (m_hold) begin
        if (!full) begin sb.push_back(m_held); m_hold = 1'b0; end
      end else if (irdy) begin
        it.inst = inst; it.pc = m_pc;
        predict(m_pc, inst, npc, it.pred, it.is_c);
        m_pc = npc;
        if (full) begin m_held = it; m_hold = 1'b1; end
        else sb.push_back(it);
      end
      if (upd) begin
        if (tk) m_bht[(upc >> 1) % 64] = (m_bht[(upc >> 1) % 64] == 3) ? 3 : m_bht[(upc >> 1) % 64] + 1;
        else    m_bht[(upc >> 1) % 64] = (m_bht[(upc >> 1) % 64] == 0) ? 0 : m_bht[(upc >> 1) % 64] - 1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input bit full);
    cycle(1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0, full);
  endtask

  task automatic do_reset();
    rdy_in = 1'b1; flush = 1'b0; br_upd_en = 1'b0; inst_rdy = 1'b0; dec_full = 1'b0;
    flush_pc = '0; br_upd_pc = '0; br_taken = 1'b0; inst_out = '0;
    rst_in = 1'b0;
    #2;
    chk("rst if2ctrl_en", {31'b0, if2ctrl_en}, 32'h1);
    chk("rst next_PC", next_PC, 32'h0);
    chk("rst if2dec_en", {31'b0, if2dec_en}, 32'h0);
    chk("rst if2dec_inst", if2dec_inst, 32'h0);
    chk("rst if2dec_pc", if2dec_pc, 32'h0);
    chk("rst flags", {30'b0, if2dec_is_c, if2dec_pred_taken}, 32'h0);
    model_reset();
    @(negedge clk); #1;
    rst_in = 1'b1;
    @(posedge clk); #1;
  endtask

  // Monitor: every new if2dec_en pulse consumes one scoreboard entry.
  initial begin
    item_t e;
    bit prev_en = 1'b0, prev_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_in !== 1'b1) begin
        prev_en = 1'b0;
      end else begin
        if (if2dec_en && !(prev_en && !prev_rdy)) begin
          if (sb.size() == 0) begin
            chk("unexpected if2dec_en", {31'b0, if2dec_en}, 32'h0);
          end else begin
            e = sb.pop_front();
            chk("if2dec_inst", if2dec_inst, e.inst);
            chk("if2dec_pc", if2dec_pc, e.pc);
            chk("if2dec_is_c", {31'b0, if2dec_is_c}, {31'b0, e.is_c});
            chk("if2dec_pred_taken", {31'b0, if2dec_pred_taken}, {31'b0, e.pred});
          end
        end
        prev_en  = if2dec_en;
        prev_rdy = rdy_in;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_in = 1'b1;
    @(posedge clk); #1;
    do_reset();

    cycle(1, 0, 0, 0, 0, 0, 1, 32'h00100093, 0);
    chk("seq next_PC", next_PC, 32'h4);
    cycle(1, 0, 0, 0, 0, 0, 1, 32'h00004501, 0);
    chk("compressed next_PC", next_PC, 32'h6);
    cycle(1, 1, 32'h10, 0, 0, 0, 0, 0, 0);
    idle(0);
    cycle(1, 0, 0, 0, 0, 0, 1, 32'h0080006F, 0);
    chk("jal next_PC", next_PC, 32'h18);
    cycle(1, 1, 32'h20, 0, 0, 0, 0, 0, 0);
    idle(0);
    cycle(1, 0, 0, 0, 0, 0, 1, 32'hFE000CE3, 0);
    chk("beq untrained next_PC", next_PC, 32'h24);
    // one taken update from the reset value 01 reaches 10: predicted taken
    cycle(1, 1, 32'h20, 1, 32'h20, 1, 0, 0, 0);
    idle(0);
    cycle(1, 0, 0, 1, 32'h20, 1, 1, 32'hFE000CE3, 0);
    chk("beq trained next_PC", next_PC, 32'h18);

    cycle(1, 0, 0, 0, 0, 0, 1, 32'h00100093, 1);
    chk("hold if2ctrl_en", {31'b0, if2ctrl_en}, 32'h0);
    idle(1);
    idle(0);
    idle(0);
    chk("after release next_PC", next_PC, 32'h1C);

    cycle(1, 1, 32'h100, 0, 0, 0, 1, 32'h0080006F, 0);
    cycle(1, 0, 0, 0, 0, 0, 1, 32'h0080006F, 0);
    chk("redirect next_PC", next_PC, 32'h100);
    chk("redirect if2ctrl_en", {31'b0, if2ctrl_en}, 32'h1);

    cycle(1, 0, 0, 0, 0, 0, 1, 32'h00100093, 1);
    cycle(1, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    idle(0);
    idle(0);
    cycle(0, 0, 0, 1, 32'h44, 0, 1, 32'h00004501, 0);
    cycle(0, 0, 0, 1, 32'h44, 0, 1, 32'h00004501, 0);
    chk("frozen next_PC", next_PC, 32'h40);
    cycle(1, 0, 0, 0, 0, 0, 1, 32'h00004501, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0);

    for (int i = 0; i < 4000; i++) begin
      bit r, f, u;
      logic [31:0] fpc, upc;
      if (i == 2000) do_reset();
      r   = ($urandom_range(0, 9) != 0);
      f   = r && ($urandom_range(0, 19) == 0);
      u   = ($urandom_range(0, 2) == 0);
      fpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : ($urandom & 32'h0000_01FF);
      upc = $urandom_range(0, 1) ? m_pc : ($urandom & 32'h0000_007F);
      cycle(r, f, fpc, u, upc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) < 3),
            gen_inst(), ($urandom_range(0, 2) == 0));
    end

    for (int i = 0; i < 6; i++) idle(0);
    chk("scoreboard drained", sb.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the memory controller/icache.
- Holds the PC and drives fetch requests (if2ctrl_en, next_PC).
- Accepts the returned instruction (inst_rdy, inst_out) and forwards it to the decoder with PC, compressed flag and a static/BHT next-PC prediction.
- Redirects to the ROB-supplied PC on flush.

Parameters:
ADDR_WIDTH, 32, PC/address width
INST_WIDTH, 32, instruction width
BHT_IDX_W, 6, log2 of BHT entries (64 two-bit counters)
RESET_PC, 32'h0, PC after reset

Ports:
clk  in  1  clock
rst_in  in  1  asynchronous, active-low reset
rdy_in  in  1  global ready; low freezes all state
flush  in  1  ROB mispredict redirect
flush_pc  in  ADDR_WIDTH  redirect target
br_upd_en  in  1  BHT update strobe from ROB commit
br_upd_pc  in  ADDR_WIDTH  PC of committed branch
br_taken  in  1  actual branch outcome
if2ctrl_en  out  1  fetch request to controller
next_PC  out  ADDR_WIDTH  fetch address
inst_rdy  in  1  instruction valid from controller (combinational on if2ctrl_en)
inst_out  in  INST_WIDTH  fetched instruction
dec_full  in  1  decoder/issue cannot accept
if2dec_en  out  1  one-cycle valid pulse to decoder
if2dec_inst  out  INST_WIDTH  instruction as received
if2dec_pc  out  ADDR_WIDTH  its PC
if2dec_is_c  out  1  inst[1:0] != 2'b11
if2dec_pred_taken  out  1  predicted redirect

Behaviour:
- Reset (rst_in=0, async): pc=RESET_PC, state=FETCH, if2dec_en=0, if2dec_inst/pc=0, is_c=0, pred_taken=0, all BHT counters=2'b01.
- rdy_in=0: no register, including the BHT, changes.
- FSM states:
  - FETCH: if2ctrl_en=1, next_PC=pc, both held stable until inst_rdy.
  - HOLD: if2ctrl_en=0; captured instruction is buffered.
  - REDIRECT: if2ctrl_en=0 for exactly one cycle after a flush.
- Capture when inst_rdy=1 in FETCH:
  - step = 2 if inst[1:0]!=2'b11, else 4.
  - JAL (opcode 1101111, non-compressed): npc = pc + sext(J-imm), pred_taken=1. J-imm = {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}.
  - BRANCH (1100011): look up BHT[pc[BHT_IDX_W:1]]. If counter>=2: npc = pc + sext(B-imm), pred_taken=1. Else npc = pc+4. B-imm = {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}.
  - All else, including JALR and every compressed instruction: npc = pc+step, pred_taken=0.
  - pc<=npc at capture. The instruction, its old PC and the flags go into the output/buffer registers.
  - dec_full=0: if2dec_en=1 in the next cycle, state stays FETCH; the new request is issued that same next cycle.
  - dec_full=1: state->HOLD, if2dec_en=0.
- HOLD: the first cycle with dec_full=0 sets if2dec_en=1 next cycle and returns to FETCH.
- if2dec_en is high for exactly one cycle per delivered instruction.
- Flush (highest priority, any state):
  - pc<=flush_pc, state->REDIRECT, if2dec_en<=0.
  - The buffered instruction is dropped.
  - inst_rdy in the flush cycle is ignored.
  - if2ctrl_en=0 combinationally in the flush cycle and in the REDIRECT cycle, then FETCH from flush_pc.
- BHT update: saturating 2-bit counter at index br_upd_pc[BHT_IDX_W:1]; increment if br_taken, else decrement.
  - A same-cycle lookup of the same index reads the old value.
  - Update is applied even during flush.
- Arithmetic is ADDR_WIDTH wrap-around; no alignment check.

Test Plan:
1. Reset: hold rst_in=0 mid-run, release -> if2ctrl_en=1, next_PC=0, if2dec_en=0; BHT reads 01.
2. Sequential: inst_out=0x00100093 at pc 0 -> next cycle if2dec_en=1, if2dec_pc=0, is_c=0, pred_taken=0, next_PC=4.
3. Compressed: at pc 4, inst_out=0x00004501 -> if2dec_is_c=1, next_PC=6.
4. JAL: pc 0x10, inst 0x0080006F -> pred_taken=1, next_PC=0x18.
5. Branch and BHT training:
   - beq 0xFE000CE3 at 0x20 -> first fetch gives next_PC=0x24, pred_taken=0.
   - Two br_upd_en with pc 0x20, taken=1 -> refetch predicts pred_taken=1, next_PC=0x18.
6. Stall and flush:
   - inst_rdy with dec_full=1 -> if2ctrl_en=0, no if2dec_en.
   - dec_full=0 -> if2dec_en pulse.
   - flush with flush_pc=0x100 during pending FETCH -> if2ctrl_en=0 for 2 cycles, then next_PC=0x100; no stale if2dec_en.
